// File: rtl/tlb_sv39_assoc_pkg.sv
// Shared Sv39 TLB definitions: PTE flag positions, level codes, privilege encodings,
// controller states and the translation helper functions used by the entries and the top.
package tlb_sv39_assoc_pkg;

    localparam int PTE_V = 0;
    localparam int PTE_R = 1;
    localparam int PTE_W = 2;
    localparam int PTE_X = 3;
    localparam int PTE_U = 4;
    localparam int PTE_G = 5;
    localparam int PTE_A = 6;
    localparam int PTE_D = 7;

    localparam int VPN_W = 27;
    localparam int PPN_W = 44;

    localparam logic [1:0] LVL_4K = 2'd0;
    localparam logic [1:0] LVL_2M = 2'd1;
    localparam logic [1:0] LVL_1G = 2'd2;

    localparam logic [1:0] MSTATUS_MPP_U = 2'b00;
    localparam logic [1:0] MSTATUS_MPP_S = 2'b01;
    localparam logic [1:0] MSTATUS_MPP_M = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WALK_REQ  = 2'd1,
        ST_WALK_WAIT = 2'd2,
        ST_REFILL    = 2'd3
    } tlb_state_e;

    // Superpage entries only compare the VPN fields above their level.
    function automatic logic vpn_match(input logic [VPN_W-1:0] a, input logic [VPN_W-1:0] b,
                                       input logic [1:0] level);
        case (level)
            LVL_1G:  return a[26:18] == b[26:18];
            LVL_2M:  return a[26:9] == b[26:9];
            default: return a == b;
        endcase
    endfunction

    function automatic logic superpage_misaligned(input logic [PPN_W-1:0] ppn, input logic [1:0] level);
        case (level)
            LVL_4K:  return 1'b0;
            LVL_2M:  return ppn[8:0] != '0;
            LVL_1G:  return ppn[17:0] != '0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [PPN_W+11:0] make_pa(input logic [PPN_W-1:0] ppn, input logic [29:0] va,
                                                 input logic [1:0] level);
        logic [PPN_W-1:0] p;
        p = ppn;
        case (level)
            LVL_1G:  p[17:0] = va[29:12];
            LVL_2M:  p[8:0]  = va[20:12];
            default: p = ppn;
        endcase
        return {p, va[11:0]};
    endfunction

    function automatic logic perm_fault(input logic [7:0] f, input logic [1:0] priv, input logic sum,
                                        input logic mxr, input logic is_store, input logic is_exec);
        logic flt;
        if (is_exec)
            flt = !f[PTE_X];
        else if (is_store)
            flt = !(f[PTE_W] && f[PTE_D]);
        else
            flt = !(f[PTE_R] || (mxr && f[PTE_X]));
        if (!f[PTE_V] || !f[PTE_A])
            flt = 1'b1;
        if (priv == MSTATUS_MPP_U && !f[PTE_U])
            flt = 1'b1;
        if (priv == MSTATUS_MPP_S && f[PTE_U] && (is_exec || !sum))
            flt = 1'b1;
        return flt;
    endfunction

endpackage

// File: rtl/tlb_sv39_entry.sv
// One TLB entry: tag/translation storage plus its lookup-hit and sfence-match logic.
module tlb_sv39_entry
    import tlb_sv39_assoc_pkg::*;
#(
    parameter int ASID_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [VPN_W-1:0]  i_wr_vpn,
    input  logic [PPN_W-1:0]  i_wr_ppn,
    input  logic [1:0]        i_wr_level,
    input  logic [ASID_W-1:0] i_wr_asid,
    input  logic [7:0]        i_wr_flags,
    input  logic              i_flush,
    input  logic              i_flush_asid_en,
    input  logic              i_flush_va_en,
    input  logic [ASID_W-1:0] i_flush_asid,
    input  logic [VPN_W-1:0]  i_flush_vpn,
    input  logic [VPN_W-1:0]  i_lk_vpn,
    input  logic [ASID_W-1:0] i_lk_asid,
    output logic              o_valid,
    output logic              o_hit,
    output logic [PPN_W-1:0]  o_ppn,
    output logic [1:0]        o_level,
    output logic [7:0]        o_flags
);

    logic              r_valid;
    logic [VPN_W-1:0]  r_vpn;
    logic [PPN_W-1:0]  r_ppn;
    logic [1:0]        r_level;
    logic [ASID_W-1:0] r_asid;
    logic [7:0]        r_flags;
    logic              w_glob;
    logic              w_flush_hit;

    assign w_glob = r_flags[PTE_G];

    assign o_hit = r_valid && (w_glob || (r_asid == i_lk_asid)) && vpn_match(r_vpn, i_lk_vpn, r_level);

    // Global entries survive an ASID-restricted flush.
    assign w_flush_hit = r_valid
                      && (!i_flush_asid_en || (!w_glob && (r_asid == i_flush_asid)))
                      && (!i_flush_va_en || vpn_match(r_vpn, i_flush_vpn, r_level));

    always_ff @(posedge i_clk) begin
        if (!i_rst)
            r_valid <= 1'b0;
        else if (i_wr_en)
            r_valid <= 1'b1;
        else if (i_flush && w_flush_hit)
            r_valid <= 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_vpn   <= i_wr_vpn;
            r_ppn   <= i_wr_ppn;
            r_level <= i_wr_level;
            r_asid  <= i_wr_asid;
            r_flags <= i_wr_flags;
        end
    end

    assign o_valid = r_valid;
    assign o_ppn   = r_ppn;
    assign o_level = r_level;
    assign o_flags = r_flags;

endmodule

// File: rtl/tlb_sv39_assoc.sv
// Fully-associative Sv39 TLB with superpages, selective sfence flush and an
// integrated miss handler that walks through the shared PTW port and refills round-robin.
module tlb_sv39_assoc
    import tlb_sv39_assoc_pkg::*;
#(
    parameter int ENTRIES = 8,
    parameter int ASID_W  = 16,
    parameter int PA_W    = 56
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_xlate_en,
    input  logic [ASID_W-1:0] i_asid,
    input  logic [1:0]        i_priv,
    input  logic              i_sum,
    input  logic              i_mxr,
    input  logic [63:0]       i_req_va,
    input  logic              i_req_is_store,
    input  logic              i_req_is_exec,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    output logic [63:0]       o_resp_pa,
    output logic              o_resp_fault,
    output logic              o_resp_valid,
    output logic [VPN_W-1:0]  o_ptw_req_vpn,
    output logic              o_ptw_req_valid,
    input  logic              i_ptw_req_ready,
    input  logic [63:0]       i_ptw_resp_pte,
    input  logic [1:0]        i_ptw_resp_level,
    input  logic              i_ptw_resp_fault,
    input  logic              i_ptw_resp_valid,
    input  logic              i_flush_valid,
    input  logic              i_flush_asid_en,
    input  logic              i_flush_va_en,
    input  logic [ASID_W-1:0] i_flush_asid,
    input  logic [VPN_W-1:0]  i_flush_vpn,
    output logic              o_flush_ready
);

    localparam int          IDX_W   = $clog2(ENTRIES);
    localparam logic [63:0] PA_MASK = (PA_W >= 64) ? '1 : ((64'd1 << PA_W) - 64'd1);

    tlb_state_e r_state, w_state_nxt;

    logic              r_resp_valid, r_resp_fault;
    logic [63:0]       r_resp_pa;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [38:0]       r_va;
    logic              r_is_store, r_is_exec, r_sum, r_mxr;
    logic [1:0]        r_priv;
    logic [ASID_W-1:0] r_asid;
    logic [PPN_W-1:0]  r_pte_ppn;
    logic [1:0]        r_pte_level;
    logic [7:0]        r_pte_flags;

    logic [ENTRIES-1:0] w_ent_valid, w_ent_hit, w_wr_en;
    logic [PPN_W-1:0]   w_ent_ppn   [ENTRIES];
    logic [1:0]         w_ent_level [ENTRIES];
    logic [7:0]         w_ent_flags [ENTRIES];

    logic              w_hit, w_bypass, w_canon, w_miss, w_accept, w_flush_go, w_walk_bad;
    logic [PPN_W-1:0]  w_hit_ppn;
    logic [1:0]        w_hit_level;
    logic [7:0]        w_hit_flags;
    logic              w_lk_fault;
    logic [63:0]       w_lk_pa;
    logic [IDX_W-1:0]  w_victim;
    logic              w_any_inv;
    logic              w_unused;

    assign w_unused = ^{i_ptw_resp_pte[63:54], i_ptw_resp_pte[9:8], w_hit_flags[PTE_G]};

    for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
        tlb_sv39_entry #(.ASID_W(ASID_W)) u_ent (
            .i_clk           (i_clk),
            .i_rst           (i_rst),
            .i_wr_en         (w_wr_en[g]),
            .i_wr_vpn        (r_va[38:12]),
            .i_wr_ppn        (r_pte_ppn),
            .i_wr_level      (r_pte_level),
            .i_wr_asid       (r_asid),
            .i_wr_flags      (r_pte_flags),
            .i_flush         (w_flush_go),
            .i_flush_asid_en (i_flush_asid_en),
            .i_flush_va_en   (i_flush_va_en),
            .i_flush_asid    (i_flush_asid),
            .i_flush_vpn     (i_flush_vpn),
            .i_lk_vpn        (i_req_va[38:12]),
            .i_lk_asid       (i_asid),
            .o_valid         (w_ent_valid[g]),
            .o_hit           (w_ent_hit[g]),
            .o_ppn           (w_ent_ppn[g]),
            .o_level         (w_ent_level[g]),
            .o_flags         (w_ent_flags[g])
        );
    end

    // Lowest matching index wins; refill discipline keeps hits unique anyway.
    always_comb begin
        w_hit       = 1'b0;
        w_hit_ppn   = '0;
        w_hit_level = LVL_4K;
        w_hit_flags = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (w_ent_hit[i]) begin
                w_hit       = 1'b1;
                w_hit_ppn   = w_ent_ppn[i];
                w_hit_level = w_ent_level[i];
                w_hit_flags = w_ent_flags[i];
            end
        end
    end

    always_comb begin
        w_victim  = r_rr_ptr;
        w_any_inv = 1'b0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!w_ent_valid[i]) begin
                w_victim  = IDX_W'(i);
                w_any_inv = 1'b1;
            end
        end
        w_wr_en = '0;
        if (r_state == ST_REFILL)
            w_wr_en[w_victim] = 1'b1;
    end

    assign w_bypass = !i_xlate_en || (i_priv == MSTATUS_MPP_M);
    assign w_canon  = (i_req_va[63:39] == {25{i_req_va[38]}});
    assign w_miss   = !w_bypass && w_canon && !w_hit;

    always_comb begin
        w_lk_fault = 1'b0;
        w_lk_pa    = i_req_va & PA_MASK;
        if (!w_bypass) begin
            if (!w_canon) begin
                w_lk_fault = 1'b1;
                w_lk_pa    = '0;
            end else begin
                w_lk_fault = perm_fault(w_hit_flags, i_priv, i_sum, i_mxr, i_req_is_store, i_req_is_exec);
                w_lk_pa    = {{(52 - PPN_W){1'b0}}, make_pa(w_hit_ppn, i_req_va[29:0], w_hit_level)} & PA_MASK;
            end
        end
    end

    assign w_walk_bad = i_ptw_resp_fault || superpage_misaligned(i_ptw_resp_pte[53:10], i_ptw_resp_level);

    always_comb begin
        w_state_nxt     = r_state;
        o_req_ready     = 1'b0;
        o_flush_ready   = 1'b0;
        o_ptw_req_valid = 1'b0;
        o_ptw_req_vpn   = '0;
        case (r_state)
            ST_IDLE: begin
                o_flush_ready = i_rst;
                o_req_ready   = i_rst && !i_flush_valid;
                if (i_req_valid && o_req_ready && w_miss)
                    w_state_nxt = ST_WALK_REQ;
            end
            ST_WALK_REQ: begin
                o_ptw_req_valid = i_rst;
                o_ptw_req_vpn   = i_rst ? r_va[38:12] : '0;
                if (i_ptw_req_ready)
                    w_state_nxt = ST_WALK_WAIT;
            end
            ST_WALK_WAIT: begin
                if (i_ptw_resp_valid)
                    w_state_nxt = w_walk_bad ? ST_IDLE : ST_REFILL;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_accept   = i_req_valid && o_req_ready;
    assign w_flush_go = i_flush_valid && o_flush_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_resp_valid <= 1'b0;
            r_resp_fault <= 1'b0;
            r_resp_pa    <= '0;
            r_rr_ptr     <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && !w_miss) begin
                        r_resp_valid <= 1'b1;
                        r_resp_fault <= w_lk_fault;
                        r_resp_pa    <= w_lk_pa;
                    end
                end
                ST_WALK_WAIT: begin
                    if (i_ptw_resp_valid && w_walk_bad) begin
                        r_resp_valid <= 1'b1;
                        r_resp_fault <= 1'b1;
                        r_resp_pa    <= '0;
                    end
                end
                ST_REFILL: begin
                    r_resp_valid <= 1'b1;
                    r_resp_fault <= perm_fault(r_pte_flags, r_priv, r_sum, r_mxr, r_is_store, r_is_exec);
                    r_resp_pa    <= {{(52 - PPN_W){1'b0}}, make_pa(r_pte_ppn, r_va[29:0], r_pte_level)} & PA_MASK;
                    if (!w_any_inv)
                        r_rr_ptr <= (r_rr_ptr == IDX_W'(ENTRIES - 1)) ? '0 : r_rr_ptr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // The request context is captured at accept so a walk finishes with the
    // privilege/ASID it started with, regardless of later CSR changes.
    always_ff @(posedge i_clk) begin
        if (r_state == ST_IDLE && w_accept) begin
            r_va       <= i_req_va[38:0];
            r_is_store <= i_req_is_store;
            r_is_exec  <= i_req_is_exec;
            r_priv     <= i_priv;
            r_sum      <= i_sum;
            r_mxr      <= i_mxr;
            r_asid     <= i_asid;
        end
        if (r_state == ST_WALK_WAIT && i_ptw_resp_valid) begin
            r_pte_ppn   <= i_ptw_resp_pte[53:10];
            r_pte_level <= i_ptw_resp_level;
            r_pte_flags <= i_ptw_resp_pte[7:0];
        end
    end

    assign o_resp_valid = r_resp_valid;
    assign o_resp_fault = r_resp_fault;
    assign o_resp_pa    = r_resp_pa;

endmodule

// File: tb/tb_tlb_sv39_assoc.sv
// Directed bench for tlb_sv39_assoc: bypass, hits, misses with walks, superpages,
// permissions, round-robin eviction, selective flushes and reset during a walk.
module tb_tlb_sv39_assoc;

    localparam int ENTRIES = 8;
    localparam int ASID_W  = 16;
    localparam int PA_W    = 56;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              xlate_en, sum, mxr;
    logic [ASID_W-1:0] asid;
    logic [1:0]        priv;
    logic [63:0]       req_va;
    logic              req_is_store, req_is_exec, req_valid, req_ready;
    logic [63:0]       resp_pa;
    logic              resp_fault, resp_valid;
    logic [26:0]       ptw_req_vpn;
    logic              ptw_req_valid, ptw_req_ready;
    logic [63:0]       ptw_resp_pte;
    logic [1:0]        ptw_resp_level;
    logic              ptw_resp_fault, ptw_resp_valid;
    logic              flush_valid, flush_asid_en, flush_va_en, flush_ready;
    logic [ASID_W-1:0] flush_asid;
    logic [26:0]       flush_vpn;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tlb_sv39_assoc #(.ENTRIES(ENTRIES), .ASID_W(ASID_W), .PA_W(PA_W)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_xlate_en       (xlate_en),
        .i_asid           (asid),
        .i_priv           (priv),
        .i_sum            (sum),
        .i_mxr            (mxr),
        .i_req_va         (req_va),
        .i_req_is_store   (req_is_store),
        .i_req_is_exec    (req_is_exec),
        .i_req_valid      (req_valid),
        .o_req_ready      (req_ready),
        .o_resp_pa        (resp_pa),
        .o_resp_fault     (resp_fault),
        .o_resp_valid     (resp_valid),
        .o_ptw_req_vpn    (ptw_req_vpn),
        .o_ptw_req_valid  (ptw_req_valid),
        .i_ptw_req_ready  (ptw_req_ready),
        .i_ptw_resp_pte   (ptw_resp_pte),
        .i_ptw_resp_level (ptw_resp_level),
        .i_ptw_resp_fault (ptw_resp_fault),
        .i_ptw_resp_valid (ptw_resp_valid),
        .i_flush_valid    (flush_valid),
        .i_flush_asid_en  (flush_asid_en),
        .i_flush_va_en    (flush_va_en),
        .i_flush_asid     (flush_asid),
        .i_flush_vpn      (flush_vpn),
        .o_flush_ready    (flush_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk_pte(input logic [43:0] ppn, input logic [7:0] flags);
        return {10'b0, ppn, 2'b00, flags};
    endfunction

    // Request that must be answered without a walk, one cycle after acceptance.
    task automatic hit_req(input string tag, input logic [63:0] va, input logic st, input logic ex,
                           input logic [63:0] exp_pa, input logic exp_fault);
        @(negedge clk);
        req_va = va; req_is_store = st; req_is_exec = ex; req_valid = 1'b1;
        #1 chk({tag, ".ready"}, req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, ".valid"}, resp_valid, 1'b1);
        chk({tag, ".fault"}, resp_fault, exp_fault);
        if (!exp_fault) chk({tag, ".pa"}, resp_pa, exp_pa);
        chk({tag, ".noptw"}, ptw_req_valid, 1'b0);
    endtask

    // Request that must miss; bench plays the PTW with zero added latency.
    task automatic miss_req(input string tag, input logic [63:0] va, input logic st, input logic ex,
                            input logic [43:0] ppn, input logic [7:0] flags, input logic [1:0] lvl,
                            input logic wflt, input logic rejected,
                            input logic [63:0] exp_pa, input logic exp_fault);
        @(negedge clk);
        req_va = va; req_is_store = st; req_is_exec = ex; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, ".nohit"}, resp_valid, 1'b0);
        chk({tag, ".ptwv"}, ptw_req_valid, 1'b1);
        chk({tag, ".vpn"}, ptw_req_vpn, va[38:12]);
        ptw_req_ready = 1'b1;
        @(negedge clk);
        ptw_req_ready = 1'b0;
        chk({tag, ".wait"}, ptw_req_valid, 1'b0);
        ptw_resp_pte = mk_pte(ppn, flags); ptw_resp_level = lvl; ptw_resp_fault = wflt;
        ptw_resp_valid = 1'b1;
        @(negedge clk);
        ptw_resp_valid = 1'b0; ptw_resp_fault = 1'b0;
        if (!rejected) begin
            chk({tag, ".refill"}, resp_valid, 1'b0);
            @(negedge clk);
        end
        chk({tag, ".valid"}, resp_valid, 1'b1);
        chk({tag, ".fault"}, resp_fault, exp_fault);
        if (!exp_fault) chk({tag, ".pa"}, resp_pa, exp_pa);
    endtask

    // Flush issued together with a request: flush must win and the request stay unaccepted.
    task automatic do_flush(input string tag, input logic aen, input logic ven,
                            input logic [ASID_W-1:0] fa, input logic [26:0] fv);
        @(negedge clk);
        flush_valid = 1'b1; flush_asid_en = aen; flush_va_en = ven; flush_asid = fa; flush_vpn = fv;
        req_va = 64'h0000_0000_2000_0000; req_valid = 1'b1;
        #1;
        chk({tag, ".fready"}, flush_ready, 1'b1);
        chk({tag, ".rblock"}, req_ready, 1'b0);
        @(negedge clk);
        flush_valid = 1'b0; req_valid = 1'b0;
        chk({tag, ".noresp"}, resp_valid, 1'b0);
    endtask

    initial begin
        xlate_en = 1'b0; asid = '0; priv = 2'b01; sum = 1'b0; mxr = 1'b0;
        req_va = '0; req_is_store = 1'b0; req_is_exec = 1'b0; req_valid = 1'b0;
        ptw_req_ready = 1'b0; ptw_resp_pte = '0; ptw_resp_level = '0;
        ptw_resp_fault = 1'b0; ptw_resp_valid = 1'b0;
        flush_valid = 1'b0; flush_asid_en = 1'b0; flush_va_en = 1'b0; flush_asid = '0; flush_vpn = '0;

        repeat (2) @(negedge clk);
        ptw_resp_valid = 1'b1;
        #1;
        chk("rst.req_ready", req_ready, 1'b0);
        chk("rst.flush_ready", flush_ready, 1'b0);
        chk("rst.resp_valid", resp_valid, 1'b0);
        chk("rst.resp_fault", resp_fault, 1'b0);
        chk("rst.resp_pa", resp_pa, 64'h0);
        chk("rst.ptw_valid", ptw_req_valid, 1'b0);
        chk("rst.ptw_vpn", ptw_req_vpn, 27'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("idle.req_ready", req_ready, 1'b1);
        chk("idle.flush_ready", flush_ready, 1'b1);
        @(negedge clk);
        ptw_resp_valid = 1'b0;
        chk("stray.resp", resp_valid, 1'b0);
        chk("stray.ready", req_ready, 1'b1);

        hit_req("bypass", 64'h8000_1234, 1'b0, 1'b0, 64'h8000_1234, 1'b0);
        xlate_en = 1'b1; priv = 2'b11;
        hit_req("mmode", 64'h4000_0000, 1'b0, 1'b0, 64'h4000_0000, 1'b0);
        priv = 2'b01; asid = 16'd1;
        hit_req("noncanon", 64'h0000_0080_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1);

        miss_req("miss4k", 64'h4000_0000, 1'b0, 1'b0, 44'h80123, 8'h47, 2'd0, 1'b0, 1'b0,
                 64'h8012_3000, 1'b0);
        hit_req("hit4k", 64'h4000_0ABC, 1'b0, 1'b0, 64'h8012_3ABC, 1'b0);
        miss_req("miss1g", 64'h3ABC_DEF0, 1'b0, 1'b0, 44'h80000, 8'hCF, 2'd2, 1'b0, 1'b0,
                 64'hBABC_DEF0, 1'b0);
        hit_req("hit1g", 64'h0000_2468, 1'b0, 1'b0, 64'h8000_2468, 1'b0);
        miss_req("misal1g", 64'h8000_0000, 1'b0, 1'b0, 44'h80001, 8'hCF, 2'd2, 1'b0, 1'b1,
                 64'h0, 1'b1);
        miss_req("walkflt", 64'h6000_0000, 1'b0, 1'b0, 44'h0, 8'h00, 2'd0, 1'b1, 1'b1,
                 64'h0, 1'b1);

        priv = 2'b00;
        hit_req("u_on_s", 64'h4000_0000, 1'b0, 1'b0, 64'h0, 1'b1);
        priv = 2'b01; sum = 1'b1;
        miss_req("s_sum", 64'h5000_0000, 1'b0, 1'b0, 44'h90000, 8'h5B, 2'd0, 1'b0, 1'b0,
                 64'h9000_0000, 1'b0);
        hit_req("s_exec_u", 64'h5000_0000, 1'b0, 1'b1, 64'h0, 1'b1);
        sum = 1'b0;
        hit_req("s_nosum", 64'h5000_0010, 1'b0, 1'b0, 64'h0, 1'b1);
        sum = 1'b1;
        hit_req("store_d0", 64'h4000_0008, 1'b1, 1'b0, 64'h0, 1'b1);
        hit_req("store_ok", 64'h0000_3000, 1'b1, 1'b0, 64'h8000_3000, 1'b0);
        hit_req("exec_ok", 64'h0000_4000, 1'b0, 1'b1, 64'h8000_4000, 1'b0);

        do_flush("flushall", 1'b0, 1'b0, '0, '0);
        miss_req("postflush", 64'h4000_0000, 1'b0, 1'b0, 44'h80123, 8'h47, 2'd0, 1'b0, 1'b0,
                 64'h8012_3000, 1'b0);
        do_flush("flushall2", 1'b0, 1'b0, '0, '0);

        for (int i = 0; i <= ENTRIES; i++) begin
            logic [43:0] ppn;
            ppn = 44'hA0000 + 44'(i);
            miss_req($sformatf("fill%0d", i), 64'h1000_0000 + 64'(i) * 64'h1000, 1'b0, 1'b0,
                     ppn, 8'hC7, 2'd0, 1'b0, 1'b0, {8'b0, ppn, 12'h000}, 1'b0);
        end
        hit_req("keep1", 64'h1000_1000, 1'b0, 1'b0, 64'hA000_1000, 1'b0);
        miss_req("evict0", 64'h1000_0000, 1'b0, 1'b0, 44'hA0000, 8'hC7, 2'd0, 1'b0, 1'b0,
                 64'hA000_0000, 1'b0);
        miss_req("evict1", 64'h1000_1000, 1'b0, 1'b0, 44'hA0001, 8'hC7, 2'd0, 1'b0, 1'b0,
                 64'hA000_1000, 1'b0);
        hit_req("keep3", 64'h1000_3000, 1'b0, 1'b0, 64'hA000_3000, 1'b0);
        hit_req("hit8", 64'h1000_8000, 1'b0, 1'b0, 64'hA000_8000, 1'b0);

        do_flush("flushall3", 1'b0, 1'b0, '0, '0);
        asid = 16'd5;
        miss_req("fill_g", 64'h2000_0000, 1'b0, 1'b0, 44'hB0000, 8'hE7, 2'd0, 1'b0, 1'b0,
                 64'hB000_0000, 1'b0);
        miss_req("fill_a5", 64'h2000_1000, 1'b0, 1'b0, 44'hB0001, 8'hC7, 2'd0, 1'b0, 1'b0,
                 64'hB000_1000, 1'b0);
        asid = 16'd6;
        miss_req("fill_a6", 64'h2000_2000, 1'b0, 1'b0, 44'hB0002, 8'hC7, 2'd0, 1'b0, 1'b0,
                 64'hB000_2000, 1'b0);
        do_flush("flush_asid5", 1'b1, 1'b0, 16'd5, '0);
        asid = 16'd5;
        hit_req("g_kept", 64'h2000_0000, 1'b0, 1'b0, 64'hB000_0000, 1'b0);
        miss_req("a5_gone", 64'h2000_1000, 1'b0, 1'b0, 44'hB0001, 8'hC7, 2'd0, 1'b0, 1'b0,
                 64'hB000_1000, 1'b0);
        asid = 16'd6;
        hit_req("a6_kept", 64'h2000_2000, 1'b0, 1'b0, 64'hB000_2000, 1'b0);
        do_flush("flush_va", 1'b0, 1'b1, '0, 27'h20002);
        miss_req("va_gone", 64'h2000_2000, 1'b0, 1'b0, 44'hB0002, 8'hC7, 2'd0, 1'b0, 1'b0,
                 64'hB000_2000, 1'b0);
        hit_req("g_after_va", 64'h2000_0000, 1'b0, 1'b0, 64'hB000_0000, 1'b0);

        @(negedge clk);
        req_va = 64'h2000_3000; req_is_store = 1'b0; req_is_exec = 1'b0; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstwalk.ptwv", ptw_req_valid, 1'b1);
        ptw_req_ready = 1'b1;
        @(negedge clk);
        ptw_req_ready = 1'b0;
        chk("rstwalk.wait", ptw_req_valid, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstwalk.idle", req_ready, 1'b1);
        chk("rstwalk.noptw", ptw_req_valid, 1'b0);
        ptw_resp_pte = mk_pte(44'hC0000, 8'hC7); ptw_resp_level = 2'd0; ptw_resp_valid = 1'b1;
        @(negedge clk);
        ptw_resp_valid = 1'b0;
        chk("rstwalk.ignored", resp_valid, 1'b0);
        chk("rstwalk.still_idle", req_ready, 1'b1);
        miss_req("after_rst", 64'h2000_0000, 1'b0, 1'b0, 44'hB0000, 8'hE7, 2'd0, 1'b0, 1'b0,
                 64'hB000_0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
